// File: rtl/bullet_pool_if.sv
// Frame-controller / plotter / hit-report bundle for the bullet pool engine.
// The engine is the slave; the frame logic and plotter side is the master.
interface bullet_pool_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int AW  = 7
);
    logic           start;
    logic           mode;
    logic [X_W-1:0] x_boss;
    logic [Y_W-1:0] y_boss;
    logic [X_W-1:0] x_player;
    logic [Y_W-1:0] y_player;
    logic [X_W-1:0] draw_x;
    logic [Y_W-1:0] draw_y;
    logic           draw_valid;
    logic           draw_ready;
    logic           hit;
    logic [7:0]     hit_count;
    logic [AW:0]    active_count;
    logic           overflow;
    logic           done;

    modport master (
        output start, mode, x_boss, y_boss, x_player, y_player, draw_ready,
        input  draw_x, draw_y, draw_valid, hit, hit_count, active_count, overflow, done
    );

    modport slave (
        input  start, mode, x_boss, y_boss, x_player, y_player, draw_ready,
        output draw_x, draw_y, draw_valid, hit, hit_count, active_count, overflow, done
    );
endinterface

// File: rtl/bullet_pool_engine.sv
// Boss-bullet pool: spawns radial/aimed bullets, walks the pool once per frame,
// hands each live bullet to the plotter, detects player hits and moves bullets.
module bullet_pool_engine #(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int DEPTH       = 128,
    parameter int BURST       = 8,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int FIRE_PERIOD = 19000000,
    parameter int HIT_R       = 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    bullet_pool_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_SCAN, S_DRAW, S_UPDATE, S_DONE} state_t;

    localparam int             FW        = $clog2(FIRE_PERIOD);
    localparam logic [FW-1:0]  FIRE_LAST = FW'(FIRE_PERIOD - 1);
    localparam logic [AW-1:0]  IDX_LAST  = AW'(DEPTH - 1);
    localparam logic [AW:0]    POOL_SIZE = (AW+1)'(DEPTH);
    localparam logic [AW:0]    BURST_N   = (AW+1)'(BURST);
    localparam logic [X_W-1:0] X_MAX     = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX     = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] HIT_RX    = X_W'(HIT_R);
    localparam logic [Y_W-1:0] HIT_RY    = Y_W'(HIT_R);
    localparam logic [1:0]     V_POS     = 2'b01;
    localparam logic [1:0]     V_NEG     = 2'b11;

    logic [X_W-1:0] x_mem  [DEPTH];
    logic [Y_W-1:0] y_mem  [DEPTH];
    logic [1:0]     vx_mem [DEPTH];
    logic [1:0]     vy_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;

    state_t         state_q;
    logic [AW-1:0]  idx_q, alloc_q;
    logic [AW:0]    spawned_q, examined_q;
    logic           mode_q;
    logic [FW-1:0]  fire_cnt_q;
    logic           fire_pending_q;
    logic [X_W-1:0] draw_x_q;
    logic [Y_W-1:0] draw_y_q;
    logic           draw_valid_q, hit_q, overflow_q, done_q;
    logic [7:0]     hit_count_q;
    logic [AW:0]    active_q;

    function automatic logic [1:0] dir_of(input logic gt, input logic lt);
        return gt ? V_POS : (lt ? V_NEG : 2'b00);
    endfunction

    logic [AW-1:0]  rd_idx;
    logic [X_W-1:0] cur_x, nx, dx;
    logic [Y_W-1:0] cur_y, ny, dy;
    logic [1:0]     cur_vx, cur_vy, sp_vx, sp_vy;
    logic           spawn_free, spawn_end, hit_now, leaves_screen;
    logic [AW:0]    target, spawned_d, examined_d;

    assign rd_idx = (state_q == S_SPAWN) ? alloc_q : idx_q;
    assign cur_x  = x_mem[rd_idx];
    assign cur_y  = y_mem[rd_idx];
    assign cur_vx = vx_mem[rd_idx];
    assign cur_vy = vy_mem[rd_idx];

    assign target     = mode_q ? (AW+1)'(1) : BURST_N;
    assign spawn_free = !valid_q[alloc_q];
    assign spawned_d  = spawned_q + (AW+1)'(spawn_free);
    assign examined_d = examined_q + (AW+1)'(1);
    assign spawn_end  = (spawned_d == target) || (examined_d == POOL_SIZE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sp_vx = 2'b00;
        sp_vy = 2'b00;
        if (mode_q) begin
            sp_vx = dir_of(bus.x_player > bus.x_boss, bus.x_player < bus.x_boss);
            sp_vy = dir_of(bus.y_player > bus.y_boss, bus.y_player < bus.y_boss);
        end else begin
            case (spawned_q[2:0])
                3'd0: begin sp_vx = V_POS; sp_vy = 2'b00; end
                3'd1: begin sp_vx = V_POS; sp_vy = V_POS; end
                3'd2: begin sp_vx = 2'b00; sp_vy = V_POS; end
                3'd3: begin sp_vx = V_NEG; sp_vy = V_POS; end
                3'd4: begin sp_vx = V_NEG; sp_vy = 2'b00; end
                3'd5: begin sp_vx = V_NEG; sp_vy = V_NEG; end
                3'd6: begin sp_vx = 2'b00; sp_vy = V_NEG; end
                default: begin sp_vx = V_POS; sp_vy = V_NEG; end
            endcase
        end
    end

    assign dx      = (draw_x_q > bus.x_player) ? draw_x_q - bus.x_player : bus.x_player - draw_x_q;
    assign dy      = (draw_y_q > bus.y_player) ? draw_y_q - bus.y_player : bus.y_player - draw_y_q;
    assign hit_now = (dx <= HIT_RX) && (dy <= HIT_RY);

    // A bullet about to step off any screen edge is retired instead of wrapping.
    assign leaves_screen = (cur_x == '0    && cur_vx == V_NEG) || (cur_x == X_MAX && cur_vx == V_POS) ||
                           (cur_y == '0    && cur_vy == V_NEG) || (cur_y == Y_MAX && cur_vy == V_POS);
    assign nx = cur_x + {{(X_W-2){cur_vx[1]}}, cur_vx};
    assign ny = cur_y + {{(Y_W-2){cur_vy[1]}}, cur_vy};

    // NOTE: slot payload is storage, not control; only valid_q needs reset, so the
    // position/velocity arrays live in a reset-free block.
    always_ff @(posedge clk) begin
        if (state_q == S_SPAWN && spawn_free) begin
            x_mem[alloc_q]  <= bus.x_boss;
            y_mem[alloc_q]  <= bus.y_boss;
            vx_mem[alloc_q] <= sp_vx;
            vy_mem[alloc_q] <= sp_vy;
        end else if (state_q == S_UPDATE && !leaves_screen) begin
            x_mem[idx_q] <= nx;
            y_mem[idx_q] <= ny;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            valid_q        <= '0;
            idx_q          <= '0;
            alloc_q        <= '0;
            spawned_q      <= '0;
            examined_q     <= '0;
            mode_q         <= 1'b0;
            fire_cnt_q     <= '0;
            fire_pending_q <= 1'b0;
            draw_x_q       <= '0;
            draw_y_q       <= '0;
            draw_valid_q   <= 1'b0;
            hit_q          <= 1'b0;
            hit_count_q    <= '0;
            active_q       <= '0;
            overflow_q     <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    idx_q <= '0;
                    if (fire_pending_q) begin
                        state_q        <= S_SPAWN;
                        mode_q         <= bus.mode;
                        spawned_q      <= '0;
                        examined_q     <= '0;
                        fire_pending_q <= 1'b0;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end
                S_SPAWN: begin
                    if (spawn_free) begin
                        valid_q[alloc_q] <= 1'b1;
                        active_q         <= active_q + 1'b1;
                    end
                    alloc_q    <= alloc_q + 1'b1;
                    spawned_q  <= spawned_d;
                    examined_q <= examined_d;
                    if (spawn_end) begin
                        state_q <= S_SCAN;
                        if (spawned_d != target) overflow_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (valid_q[idx_q]) begin
                        state_q      <= S_DRAW;
                        draw_valid_q <= 1'b1;
                        draw_x_q     <= cur_x;
                        draw_y_q     <= cur_y;
                    end else if (idx_q == IDX_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DRAW: if (bus.draw_ready) begin
                    draw_valid_q <= 1'b0;
                    if (hit_now) begin
                        hit_q          <= 1'b1;
                        hit_count_q    <= (hit_count_q == 8'hFF) ? hit_count_q : hit_count_q + 1'b1;
                        valid_q[idx_q] <= 1'b0;
                        active_q       <= active_q - 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SCAN;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end else begin
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (leaves_screen) begin
                        valid_q[idx_q] <= 1'b0;
                        active_q       <= active_q - 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_SCAN;
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A fire event landing on the SPAWN-entry edge stays pending for the next frame.
            if (fire_cnt_q == FIRE_LAST) begin
                fire_cnt_q     <= '0;
                fire_pending_q <= 1'b1;
            end else begin
                fire_cnt_q <= fire_cnt_q + 1'b1;
            end
        end
    end

    assign bus.draw_x       = draw_x_q;
    assign bus.draw_y       = draw_y_q;
    assign bus.draw_valid   = draw_valid_q;
    assign bus.hit          = hit_q;
    assign bus.hit_count    = hit_count_q;
    assign bus.active_count = active_q;
    assign bus.overflow     = overflow_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_bullet_pool_engine.sv
// Bench for bullet_pool_engine: directed frames plus random frames, each checked
// against a slot-array model evaluated frame by frame.
module tb_bullet_pool_engine;
    localparam int X_W = 8, Y_W = 7, DEPTH = 16, AW = 4, BURST = 8;
    localparam int SW = 160, SH = 120, FP = 4, HIT_R = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bullet_pool_if #(.X_W(X_W), .Y_W(Y_W), .AW(AW)) bus ();

    bullet_pool_engine #(
        .X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH), .BURST(BURST), .SCREEN_W(SW),
        .SCREEN_H(SH), .FIRE_PERIOD(FP), .HIT_R(HIT_R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct { bit v; int x; int y; int vx; int vy; } slot_t;
    typedef struct { int x; int y; bit h; } draw_t;

    slot_t pool [DEPTH];
    draw_t exp_q [$];
    int    m_alloc, m_active, m_hits;
    bit    m_ovf;
    int    tvx [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int    tvy [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
    int    total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sgn(input int a);
        return (a > 0) ? 1 : ((a < 0) ? -1 : 0);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic void model_clear();
        foreach (pool[i]) pool[i] = '{0, 0, 0, 0, 0};
        m_alloc = 0; m_active = 0; m_hits = 0; m_ovf = 0;
        exp_q.delete();
    endfunction

    // Returns the number of slots examined during the spawn phase.
    function automatic int model_spawn(input bit mode, input int bx, input int by, input int px, input int py);
        int target = mode ? 1 : BURST;
        int made = 0, exam = 0;
        while (made < target && exam < DEPTH) begin
            if (!pool[m_alloc].v) begin
                if (mode) pool[m_alloc] = '{1, bx, by, sgn(px - bx), sgn(py - by)};
                else      pool[m_alloc] = '{1, bx, by, tvx[made % 8], tvy[made % 8]};
                made++;
                m_active++;
            end
            exam++;
            m_alloc = (m_alloc + 1) % DEPTH;
        end
        if (made < target) m_ovf = 1;
        return exam;
    endfunction

    // Queues the expected draws and returns the scan/draw/update cycle cost.
    function automatic int model_frame(input int px, input int py);
        int cost = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            if (pool[i].v) begin
                bit h = iabs(pool[i].x - px) <= HIT_R && iabs(pool[i].y - py) <= HIT_R;
                int nx = pool[i].x + pool[i].vx;
                int ny = pool[i].y + pool[i].vy;
                exp_q.push_back('{pool[i].x, pool[i].y, h});
                if (h) begin
                    pool[i].v = 0;
                    m_active--;
                    if (m_hits < 255) m_hits++;
                    cost += 1;
                end else begin
                    cost += 2;
                    if (nx < 0 || nx >= SW || ny < 0 || ny >= SH) begin
                        pool[i].v = 0;
                        m_active--;
                    end else begin
                        pool[i].x = nx;
                        pool[i].y = ny;
                    end
                end
            end
        end
        return cost;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.draw_ready = 1'b0;
        #1;
        check("rst_draw_valid", bus.draw_valid, 0);
        check("rst_draw_xy", {bus.draw_x, bus.draw_y}, 0);
        check("rst_hit", bus.hit, 0);
        check("rst_hit_count", bus.hit_count, 0);
        check("rst_active", bus.active_count, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic run_frame(input bit mode, input int bx, input int by, input int px, input int py,
                             input bit spawn, input int stall_pct);
        int exam = 0, cost, cyc, stalls = 0;
        bit hit_next = 0, seen_done = 0, hold = 0;
        logic [X_W-1:0] hx;
        logic [Y_W-1:0] hy;
        draw_t d;
        bus.mode = mode;
        bus.x_boss = bx[X_W-1:0];   bus.y_boss = by[Y_W-1:0];
        bus.x_player = px[X_W-1:0]; bus.y_player = py[Y_W-1:0];
        if (spawn) begin
            repeat (6) @(negedge clk);
            exam = model_spawn(mode, bx, by, px, py);
        end
        cost = model_frame(px, py);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!seen_done && cyc < 2000) begin
            check("hit_pulse", bus.hit, hit_next);
            hit_next = 0;
            if (bus.done) begin
                seen_done = 1;
            end else begin
                if (hold) begin
                    check("hold_valid", bus.draw_valid, 1);
                    check("hold_x", bus.draw_x, hx);
                    check("hold_y", bus.draw_y, hy);
                end
                hold = 0;
                if (bus.draw_valid) begin
                    bus.draw_ready = ($urandom_range(99) >= stall_pct);
                    if (bus.draw_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_draw", 1, 0);
                        end else begin
                            d = exp_q.pop_front();
                            check("draw_x", bus.draw_x, d.x);
                            check("draw_y", bus.draw_y, d.y);
                            hit_next = d.h;
                        end
                    end else begin
                        stalls++;
                        hold = 1;
                        hx = bus.draw_x;
                        hy = bus.draw_y;
                    end
                end else begin
                    bus.draw_ready = 1'($urandom_range(1));
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", seen_done, 1);
        check("done_latency", cyc, exam + cost + stalls + 1);
        check("draws_missing", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("active_count", bus.active_count, m_active);
        check("hit_count", bus.hit_count, m_hits);
        check("overflow", bus.overflow, m_ovf);
    endtask

    task automatic reset_in_draw();
        int n = 0;
        bus.mode = 1'b0;
        bus.x_boss = 8'd40; bus.y_boss = 7'd30;
        bus.x_player = 8'd0; bus.y_player = 7'd0;
        bus.draw_ready = 1'b0;
        repeat (6) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.draw_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_draw", bus.draw_valid, 1);
        apply_reset();
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.draw_ready = 1'b0;
        bus.x_boss = '0; bus.y_boss = '0; bus.x_player = '0; bus.y_player = '0;
        apply_reset();

        // Empty frame before the first fire event, then three radial fires filling the pool.
        run_frame(0, 80, 60, 0, 0, 0, 0);
        run_frame(0, 80, 60, 0, 0, 1, 0);
        run_frame(0, 80, 60, 0, 0, 1, 0);
        run_frame(0, 80, 60, 0, 0, 1, 20);
        check("pool_full", bus.active_count, DEPTH);
        check("pool_overflow", bus.overflow, 1);

        // Aimed shots toward the upper right.
        apply_reset();
        run_frame(0, 10, 10, 50, 5, 0, 0);
        for (int i = 0; i < 3; i++) run_frame(1, 10, 10, 50, 5, 1, 0);

        // Edge retirement on the right and left borders.
        apply_reset();
        run_frame(1, 159, 20, 200, 20, 1, 0);
        run_frame(0, 0, 50, 120, 100, 1, 30);
        run_frame(0, 0, 50, 120, 100, 1, 0);

        // Player sitting on the radial burst origin.
        apply_reset();
        run_frame(0, 80, 60, 81, 60, 1, 0);
        run_frame(0, 80, 60, 81, 60, 1, 50);

        // Long plotter stalls, then reset while a draw is pending.
        run_frame(0, 30, 40, 0, 0, 1, 85);
        reset_in_draw();
        run_frame(0, 30, 40, 0, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            int bx = $urandom_range(SW - 1);
            int by = $urandom_range(SH - 1);
            int px = $urandom_range(255);
            int py = $urandom_range(127);
            if ($urandom_range(1) == 1) begin
                px = bx + $urandom_range(4);
                py = by + $urandom_range(2);
            end
            run_frame(1'($urandom_range(1)), bx, by, px, py, 1, 30);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
